// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle between the control unit and the
// multicycle multiply/divide unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             mult_start;
  logic             div_start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy;
  logic             done;
  logic             div_zero;

  // Control side: issues requests, reads HI/LO and status
  modport master (
    output mult_start, div_start, op_a, op_b,
    input  hi_out, lo_out, busy, done, div_zero
  );

  // Unit side
  modport slave (
    input  mult_start, div_start, op_a, op_b,
    output hi_out, lo_out, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed multiplier (radix-2 Booth) and divider (restoring, on
// magnitudes, MIPS sign rules). One bit per clock; HI/LO held between ops.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  mult_div_unit_if.slave  mdu
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]   cnt;
  logic               last;

  // Booth datapath: {A, Q, q-1}
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH:0]   acc_next;
  logic [WIDTH:0]     booth_sum;
  logic [WIDTH-1:0]   mcand;

  // Restoring divide datapath
  logic [WIDTH-1:0]   rem, quo, dvsr;
  logic [WIDTH:0]     shifted, trial;
  logic [WIDTH-1:0]   rem_next, quo_next;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic               neg_q, neg_r, dz;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dz_q;

  assign last  = (cnt == CNT_W'(WIDTH - 1));
  assign abs_a = mdu.op_a[WIDTH-1] ? -mdu.op_a : mdu.op_a;
  assign abs_b = mdu.op_b[WIDTH-1] ? -mdu.op_b : mdu.op_b;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: starts only honoured in IDLE; divide by zero skips iteration
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mdu.mult_start)     state_next = MULT;
        else if (mdu.div_start) state_next = (mdu.op_b == '0) ? FINISH : DIV;
      end
      MULT, DIV: if (last) state_next = FINISH;
      FINISH:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    mdu.busy = (state == MULT) || (state == DIV);
  end

  // Booth step: the add is done one bit wider so the shifted-in sign is the
  // true sign even when the multiplicand is the most negative value.
  always_comb begin
    booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    case (acc[1:0])
      2'b01:   booth_sum = booth_sum + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = booth_sum - {mcand[WIDTH-1], mcand};
      default: booth_sum = booth_sum;
    endcase
    acc_next = {booth_sum, acc[WIDTH:1]};
  end

  // Restoring divide step and final sign correction
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, dvsr};
    rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
    q_fix    = neg_q ? -quo_next : quo_next;
    r_fix    = neg_r ? -rem_next : rem_next;
  end

  // Operand latch, iteration and result staging
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mdu.mult_start) begin
            acc   <= {{WIDTH{1'b0}}, mdu.op_b, 1'b0};
            mcand <= mdu.op_a;
            cnt   <= '0;
            dz    <= 1'b0;
          end else if (mdu.div_start) begin
            rem   <= '0;
            quo   <= abs_a;
            dvsr  <= abs_b;
            neg_q <= mdu.op_a[WIDTH-1] ^ mdu.op_b[WIDTH-1];
            neg_r <= mdu.op_a[WIDTH-1];
            dz    <= (mdu.op_b == '0);
            cnt   <= '0;
          end
        end
        MULT: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            res_hi <= acc_next[2*WIDTH:WIDTH+1];
            res_lo <= acc_next[WIDTH:1];
          end
        end
        DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            res_hi <= r_fix;
            res_lo <= q_fix;
          end
        end
        default: ;
      endcase
    end
  end

  // HI/LO and completion pulses; HI/LO untouched on divide by zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= (state == FINISH);
      dz_q   <= (state == FINISH) && dz;
      if ((state == FINISH) && !dz) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign mdu.hi_out   = hi_q;
  assign mdu.lo_out   = lo_q;
  assign mdu.done     = done_q;
  assign mdu.div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: cycle-level arithmetic model plus directed
// vectors with literal HI/LO/latency expectations.
module tb_mult_div_unit;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mult_div_unit_if #(.WIDTH(W)) mdu();

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .mdu   (mdu)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: iterations remaining, pending completion, architectural HI/LO
  int           m_iter   = 0;
  bit           m_fin    = 1'b0;
  bit           m_fin_dz = 1'b0;
  logic [31:0]  m_fin_hi = '0, m_fin_lo = '0;
  logic [31:0]  m_hi = '0, m_lo = '0;
  bit           m_done = 1'b0, m_dz = 1'b0;

  always @(posedge clock or negedge reset) begin
    longint sa, sb, p, q, r;
    if (!reset) begin
      m_iter = 0; m_fin = 0; m_hi = '0; m_lo = '0; m_done = 0; m_dz = 0;
    end else begin
      m_done = 0;
      m_dz   = 0;
      if (m_fin) begin
        m_done = 1;
        m_dz   = m_fin_dz;
        if (!m_fin_dz) begin
          m_hi = m_fin_hi;
          m_lo = m_fin_lo;
        end
        m_fin = 0;
      end else if (m_iter > 0) begin
        m_iter--;
        if (m_iter == 0) m_fin = 1;
      end else begin
        sa = $signed(mdu.op_a);
        sb = $signed(mdu.op_b);
        if (mdu.mult_start) begin
          p = sa * sb;
          m_fin_hi = p[63:32];
          m_fin_lo = p[31:0];
          m_fin_dz = 0;
          m_iter   = W;
        end else if (mdu.div_start) begin
          if (sb == 0) begin
            m_fin_dz = 1;
            m_fin    = 1;
          end else begin
            q = sa / sb;
            r = sa % sb;
            m_fin_hi = r[31:0];
            m_fin_lo = q[31:0];
            m_fin_dz = 0;
            m_iter   = W;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (reset) begin
      check("busy",     64'(mdu.busy),     64'(m_iter > 0));
      check("done",     64'(mdu.done),     64'(m_done));
      check("div_zero", 64'(mdu.div_zero), 64'(m_dz));
      check("hi_out",   64'(mdu.hi_out),   64'(m_hi));
      check("lo_out",   64'(mdu.lo_out),   64'(m_lo));
    end
  end

  task automatic run_op(input bit dm, input bit dd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input bit edz,
                        input int elat, input string tag);
    int lat;
    @(negedge clock);
    mdu.mult_start = dm;
    mdu.div_start  = dd;
    mdu.op_a = a;
    mdu.op_b = b;
    @(negedge clock);
    mdu.mult_start = 0;
    mdu.div_start  = 0;
    mdu.op_a = $urandom;
    mdu.op_b = $urandom;
    lat = 0;
    while (!mdu.done && lat < 60) begin
      @(negedge clock);
      lat++;
    end
    check({tag, ".latency"},  64'(lat),          64'(elat));
    check({tag, ".hi"},       64'(mdu.hi_out),   64'(ehi));
    check({tag, ".lo"},       64'(mdu.lo_out),   64'(elo));
    check({tag, ".div_zero"}, 64'(mdu.div_zero), 64'(edz));
  endtask

  initial begin
    int nd, dl;
    logic [31:0] chi, clo;
    mdu.mult_start = 0;
    mdu.div_start  = 0;
    mdu.op_a = '0;
    mdu.op_b = '0;

    #2 reset = 1'b0;
    #1;
    check("rst.hi",   64'(mdu.hi_out),   64'h0);
    check("rst.lo",   64'(mdu.lo_out),   64'h0);
    check("rst.busy", 64'(mdu.busy),     64'h0);
    check("rst.done", 64'(mdu.done),     64'h0);
    check("rst.dz",   64'(mdu.div_zero), 64'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    run_op(1, 0, 32'd6,        32'd7,        32'h0,        32'h2A,       0, 33, "mul6x7");
    run_op(1, 0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 0, 33, "mulneg3x5");
    run_op(1, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        0, 33, "mulminmin");
    run_op(1, 0, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 0, 33, "mulx_neg1");
    run_op(0, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33, "divneg7by2");
    run_op(0, 1, 32'd7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 0, 33, "div7byneg2");
    run_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 0, 33, "divminbyneg1");
    run_op(0, 1, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h2,        0, 33, "divneg8byneg3");
    run_op(0, 1, 32'd100,      32'hFFFFFFFD, 32'h1,        32'hFFFFFFDF, 0, 33, "div100byneg3");
    run_op(0, 1, 32'h451,      32'h20,       32'h11,       32'h22,       0, 33, "div451by20");
    run_op(0, 1, 32'h1234,     32'h0,        32'h11,       32'h22,       1, 1,  "divzero");

    // Asynchronous reset in the middle of a multiply
    @(negedge clock);
    mdu.mult_start = 1; mdu.op_a = 32'd6; mdu.op_b = 32'd7;
    @(negedge clock);
    mdu.mult_start = 0;
    repeat (8) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("midrst.hi",   64'(mdu.hi_out),   64'h0);
    check("midrst.lo",   64'(mdu.lo_out),   64'h0);
    check("midrst.busy", 64'(mdu.busy),     64'h0);
    check("midrst.done", 64'(mdu.done),     64'h0);
    check("midrst.dz",   64'(mdu.div_zero), 64'h0);
    @(negedge clock);
    reset = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mdu.done) nd++;
    end
    check("midrst.no_done", 64'(nd), 64'h0);
    run_op(1, 0, 32'd6, 32'd7, 32'h0, 32'h2A, 0, 33, "mul6x7_after_rst");

    // div_start during cycle 5 of a multiply must be dropped
    @(negedge clock);
    mdu.mult_start = 1; mdu.op_a = 32'd6; mdu.op_b = 32'd7;
    @(negedge clock);
    mdu.mult_start = 0;
    nd = 0; dl = 0; chi = '0; clo = '0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clock);
      if (i == 4) begin
        mdu.div_start = 1; mdu.op_a = 32'd100; mdu.op_b = 32'd3;
      end
      if (i == 5) mdu.div_start = 0;
      if (mdu.done) begin
        nd++;
        dl = i;
        chi = mdu.hi_out;
        clo = mdu.lo_out;
      end
    end
    check("busystart.done_count", 64'(nd),  64'd1);
    check("busystart.latency",    64'(dl),  64'd33);
    check("busystart.hi",         64'(chi), 64'h0);
    check("busystart.lo",         64'(clo), 64'h2A);

    run_op(1, 1, 32'd6, 32'd7, 32'h0, 32'h2A, 0, 33, "both_starts");

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multicycle signed multiplier/divider for the MIPS datapath. It sits directly downstream of the control unit's MULT/DIV sequencing. It takes operands from the A/B registers, iterates one bit per clock, and produces the 64-bit HI/LO result written by MULT, DIV, MFHI and MFLO. Control starts an operation with a one-cycle pulse and waits for `done` instead of running its own 32-cycle counter.

Parameters:
- WIDTH, 32, operand width; hi_out/lo_out are WIDTH each.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clock  input  1  system clock; rising-edge.
- reset  input  1  asynchronous, active-low reset.
- mult_start  input  1  one-cycle request: signed multiply op_a*op_b.
- div_start  input  1  one-cycle request: signed divide op_a/op_b.
- op_a  input  WIDTH  multiplicand / dividend (RegA).
- op_b  input  WIDTH  multiplier / divisor (RegB).
- hi_out  output  WIDTH  product[63:32] or remainder.
- lo_out  output  WIDTH  product[31:0] or quotient.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse: hi_out/lo_out just updated (or div-by-zero detected).
- div_zero  output  1  one-cycle pulse, coincident with done, on divide by zero.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0, any time, including mid-operation):
  - state=IDLE, counter=0, internal shift registers=0.
  - hi_out=0, lo_out=0, busy=0, done=0, div_zero=0.
  - An aborted operation leaves no result.
- States:
  - IDLE: busy=0. On an edge with mult_start=1, latch op_a/op_b and go to MULT. Else, on div_start=1, go to DIV. mult_start has priority if both are high.
  - MULT: radix-2 Booth. Each cycle, add/sub the multiplicand into a 2*WIDTH+1 accumulator per the {q0,q-1} pair, then arithmetic shift right 1. Runs for WIDTH cycles.
  - DIV: restoring division on |op_a|, |op_b| (unsigned magnitudes). Each cycle, shift remainder:quotient left 1, trial-subtract the divisor, restore if negative. Runs for WIDTH cycles.
  - FINISH: one cycle. Register hi_out/lo_out, pulse done=1, return to IDLE.
- Division signs (MIPS semantics):
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Sign correction is applied when entering FINISH.
- Division special cases:
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No overflow flag.
  - Divide by zero: detected in the acceptance cycle. Go directly to FINISH without iterating. done=1 and div_zero=1 on the next cycle. hi_out/lo_out keep their previous values.
- Latency (start sampled at edge E0): busy=1 from E0 to E(WIDTH). Results and done appear at edge E(WIDTH+1), i.e. 33 cycles for WIDTH=32. done drops on the following edge.
- Start pulses while busy=1 or in FINISH are ignored, not queued.
- op_a/op_b may change after acceptance; they are latched internally.
- hi_out/lo_out hold their value between completions. This allows MFHI/MFLO at any later time.
- Arithmetic:
  - Booth accumulator is WIDTH*2+1 bits; the final product is bits [2*WIDTH:1].
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned.

Test Plan:
- MULT 6*7: pulse mult_start → busy for 32 cycles; on cycle 33 done=1, hi=0x00000000, lo=0x0000002A.
- MULT signed: (-3)*5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Also 0x80000000*0x80000000 → hi=0x40000000, lo=0x00000000.
- DIV signs:
  - -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 7/-2 → lo=0xFFFFFFFD, hi=0x00000001.
  - 0x80000000/-1 → lo=0x80000000, hi=0.
- Divide by zero: prior result hi=0x11, lo=0x22; div_start with op_b=0 → next cycle done=1 and div_zero=1, hi/lo unchanged, busy never asserted.
- Reset mid-op: mult_start, then reset=0 asynchronously at cycle 10 → all outputs 0 immediately. Release reset → IDLE, no done pulse. A fresh 6*7 still gives 42 at cycle 33.
- Start while busy: div_start at cycle 5 of a MULT → ignored; only the MULT result appears, with one done pulse. Simultaneous mult_start+div_start → multiply result.
